hough_vote_sequencer: RTL

Controller for a Hough transform vote pass that sequences the rho-calculation datapath and the accumulator RAM.
- Clears the accumulator, then pops edge-pixel coordinates from a FIFO.
- Sweeps every theta index per pixel into the rho datapath.
- Performs a saturating read-modify-write increment in the accumulator for each returned (rho, theta).
- Sits between the edge-detect output FIFO and the accumulator BRAM that the peak finder reads later.

---
 rtl/hough_vote_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hough_vote_sequencer.sv
// Hough vote pass controller: clears the accumulator, sweeps theta per edge pixel,
// saturating RMW votes. Optional vote counters under HOUGH_VOTE_STATS_EN.
module hough_vote_sequencer #(
   parameter int X_BITS          = 10,
   parameter int Y_BITS          = 10,
   parameter int THETAS          = 180,
   parameter int THETA_BITS      = 8,
   parameter int RHOS            = 1800,
   parameter int RHO_BITS        = 12,
   parameter int ACC_ADDR_BITS   = 19,
   parameter int COUNT_BITS      = 8,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       pix_empty,
   output logic                       pix_rd_en,
   input  logic [X_BITS+Y_BITS:0]     pix_dout,
   output logic                       calc_valid,
   input  logic                       calc_ready,
   output logic [X_BITS-1:0]          calc_x,
   output logic [Y_BITS-1:0]          calc_y,
   output logic [THETA_BITS-1:0]      calc_theta,
   input  logic                       rho_valid,
   input  logic [RHO_BITS-1:0]        rho_in,
   input  logic [THETA_BITS-1:0]      rho_theta,
   output logic [ACC_ADDR_BITS-1:0]   acc_rd_addr,
   input  logic [COUNT_BITS-1:0]      acc_rd_data,
   output logic                       acc_wr_en,
   output logic [ACC_ADDR_BITS-1:0]   acc_wr_addr,
   output logic [COUNT_BITS-1:0]      acc_wr_data
`ifdef HOUGH_VOTE_STATS_EN
   ,
   output logic [31:0]                votes_cast,
   output logic [31:0]                votes_dropped
`endif
);

   localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ACC_ADDR_BITS-1:0] LAST_CELL  = ACC_ADDR_BITS'(RHOS * THETAS - 1);
   localparam logic [ACC_ADDR_BITS-1:0] THETA_MUL  = ACC_ADDR_BITS'(THETAS);
   localparam logic [THETA_BITS-1:0]    LAST_THETA = THETA_BITS'(THETAS - 1);
   localparam logic [RHO_BITS-1:0]      RHO_LIM    = RHO_BITS'(RHOS);
   localparam logic [OUT_BITS-1:0]      OUT_MAX    = OUT_BITS'(MAX_OUTSTANDING);
   localparam logic [COUNT_BITS-1:0]    CNT_MAX    = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_SWEEP, S_DRAIN, S_DONE
   } state_t;

   state_t                    state, state_nx;
   logic [ACC_ADDR_BITS-1:0]  clr_addr;
   logic [X_BITS-1:0]         px;
   logic [Y_BITS-1:0]         py;
   logic                      plast;
   logic [THETA_BITS-1:0]     theta;
   logic [OUT_BITS-1:0]       outstanding;
   logic                      v1_valid;
   logic [ACC_ADDR_BITS-1:0]  v1_addr;
   logic                      pw_valid;
   logic [ACC_ADDR_BITS-1:0]  pw_addr;
   logic [COUNT_BITS-1:0]     pw_data;
   logic                      accept;
   logic                      in_range;
   logic                      dec;
   logic [ACC_ADDR_BITS-1:0]  vote_addr;
   logic [COUNT_BITS-1:0]     old_val;

   assign accept    = calc_valid && calc_ready;
   assign in_range  = rho_in < RHO_LIM;
   assign dec       = rho_valid && (outstanding != '0);
   assign vote_addr = ACC_ADDR_BITS'(rho_in) * THETA_MUL
                    + ACC_ADDR_BITS'(rho_theta);
   assign old_val   = (pw_valid && pw_addr == v1_addr) ? pw_data : acc_rd_data;
   assign calc_x    = px;
   assign calc_y    = py;
   assign calc_theta = theta;

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_CLEAR;
         S_CLEAR: if (clr_addr == LAST_CELL) state_nx = S_FETCH;
         S_FETCH: if (!pix_empty) state_nx = S_SWEEP;
         S_SWEEP: if (accept && theta == LAST_THETA)
                     state_nx = plast ? S_DRAIN : S_FETCH;
         S_DRAIN: if (outstanding == '0 && !v1_valid) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // outputs: handshakes, clear writes and vote writes share the write port
   always_comb begin
      busy        = (state != S_IDLE) && (state != S_DONE);
      done        = state == S_DONE;
      pix_rd_en   = (state == S_FETCH) && !pix_empty;
      calc_valid  = (state == S_SWEEP) && (outstanding < OUT_MAX);
      acc_rd_addr = (rho_valid && in_range) ? vote_addr : '0;
      acc_wr_en   = 1'b0;
      acc_wr_addr = '0;
      acc_wr_data = '0;
      if (state == S_CLEAR) begin
         acc_wr_en   = 1'b1;
         acc_wr_addr = clr_addr;
      end else if (v1_valid) begin
         acc_wr_en   = 1'b1;
         acc_wr_addr = v1_addr;
         acc_wr_data = (old_val == CNT_MAX) ? old_val : old_val + 1'b1;
      end
   end

   // clear address, pixel latch, theta sweep and outstanding tracking
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clr_addr    <= '0;
         px          <= '0;
         py          <= '0;
         plast       <= 1'b0;
         theta       <= '0;
         outstanding <= '0;
      end else begin
         if (state == S_CLEAR)
            clr_addr <= (clr_addr == LAST_CELL) ? '0 : clr_addr + 1'b1;
         if (pix_rd_en) begin
            px    <= pix_dout[X_BITS-1:0];
            py    <= pix_dout[X_BITS +: Y_BITS];
            plast <= pix_dout[X_BITS+Y_BITS];
            theta <= '0;
         end else if (accept) begin
            theta <= theta + 1'b1;
         end
         // stray results never underflow the counter
         if (accept && !dec)      outstanding <= outstanding + 1'b1;
         else if (!accept && dec) outstanding <= outstanding - 1'b1;
      end
   end

   // vote pipeline: V0 address -> V1 read-modify-write, last write kept for forwarding
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v1_valid <= 1'b0;
         v1_addr  <= '0;
         pw_valid <= 1'b0;
         pw_addr  <= '0;
         pw_data  <= '0;
      end else begin
         v1_valid <= rho_valid && in_range;
         v1_addr  <= vote_addr;
         pw_valid <= acc_wr_en;
         pw_addr  <= acc_wr_addr;
         pw_data  <= acc_wr_data;
      end
   end

`ifdef HOUGH_VOTE_STATS_EN
   // vote statistics, cleared when a pass starts
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         votes_cast    <= '0;
         votes_dropped <= '0;
      end else if (state == S_IDLE && start) begin
         votes_cast    <= '0;
         votes_dropped <= '0;
      end else begin
         if (v1_valid)               votes_cast    <= votes_cast + 1;
         if (rho_valid && !in_range) votes_dropped <= votes_dropped + 1;
      end
   end
`endif

endmodule
